// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants and the loader FSM state type for the instruction-memory loader.
package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 12;
    localparam int IMEM_MAX_WORDS  = (2 ** IMEM_ADDR_WIDTH) / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } imem_load_state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Word stream plus memory byte-write port between a producer/memory and the loader.
// Stream: a word transfers on a rising edge where in_valid && in_ready are both high;
// the producer holds in_data stable while in_valid is high and not yet accepted.
interface imem_load_if #(
    parameter int ADDR_WIDTH = imem_pkg::IMEM_ADDR_WIDTH
);

    logic                  in_valid;
    logic [31:0]           in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;

    // slave: the loader, consuming the stream and driving the memory port
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    // master: the producer and memory side
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_load_ctrl_byte_sequencer.sv
// Splits a captured 32-bit word into four consecutive byte writes, LSB first.
module imem_byte_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] word,
    output logic        we,
    output logic [1:0]  offset,
    output logic [7:0]  byte_data,
    output logic        last
);

    logic        active;
    logic [1:0]  idx;
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            idx    <= 2'd0;
            word_q <= 32'd0;
        end else if (go) begin
            active <= 1'b1;
            idx    <= 2'd0;
            word_q <= word;
        end else if (active) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                active <= 1'b0;
            end
        end
    end

    assign we        = active;
    assign offset    = idx;
    assign byte_data = word_q[{idx, 3'b000} +: 8];
    assign last      = active && (idx == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Run-time instruction-memory loader: stalls the CPU, streams words in, writes them bytewise.
// Optional running checksum of accepted words when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] len,
    imem_load_if.slave            bus,
    output logic                  cpu_stall,
    output logic                  done,
    output logic                  error,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output imem_load_state_t      state_dbg
);

    localparam int LW = ADDR_WIDTH - 1;
    localparam logic [LW-1:0] MAX_WORDS = LW'((2 ** ADDR_WIDTH) / 4);

    imem_load_state_t      state, state_next;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         word_cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic                  len_ok;
    logic                  can_start;
    logic                  load_start;
    logic                  accept;
    logic                  seq_go;
    logic                  seq_we;
    logic                  seq_last;
    logic [1:0]            seq_offset;
    logic [7:0]            seq_byte;

    assign len_ok     = (len != '0) && (len <= MAX_WORDS);
    assign can_start  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    assign load_start = can_start && start && len_ok;
    assign accept     = (state == ST_WAIT) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        seq_go     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = len_ok ? ST_WAIT : ST_ERROR;
                end else if (state == ST_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.in_valid) begin
                    seq_go     = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (seq_last) begin
                    state_next = (LW'(word_cnt + 1'b1) == len_q) ? ST_DONE : ST_WAIT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counters are owned here; the sequencer only knows about the word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            word_cnt <= '0;
            base     <= '0;
        end else if (load_start) begin
            len_q    <= len;
            word_cnt <= '0;
            base     <= '0;
        end else if (seq_last) begin
            word_cnt <= word_cnt + 1'b1;
            base     <= base + ADDR_WIDTH'(4);
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= 32'd0;
        end else if (load_start) begin
            checksum <= 32'd0;
        end else if (accept) begin
            checksum <= checksum + bus.in_data;
        end
    end
`endif

    imem_byte_sequencer u_seq (
        .clk       (clk),
        .rst       (rst),
        .go        (seq_go),
        .word      (bus.in_data),
        .we        (seq_we),
        .offset    (seq_offset),
        .byte_data (seq_byte),
        .last      (seq_last)
    );

    // Address and data are forced to zero outside byte writes so the port idles clean.
    assign bus.mem_we    = seq_we;
    assign bus.mem_addr  = seq_we ? (base + ADDR_WIDTH'(seq_offset)) : '0;
    assign bus.mem_wdata = seq_we ? seq_byte : 8'd0;
    assign bus.in_ready  = (state == ST_WAIT);
    assign cpu_stall     = (state == ST_WAIT) || (state == ST_WRITE);
    assign done          = (state == ST_DONE);
    assign error         = (state == ST_ERROR);
    assign state_dbg     = state;

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Run-time loader controller for the 4 KB byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each word as four little-endian byte writes (LSB at lowest address) through the memory's byte write port.
- Holds the CPU stalled for the whole load, checks the requested length against memory capacity, and signals completion or error.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte address width; capacity 2**ADDR_WIDTH bytes
- MAX_WORDS, 2**ADDR_WIDTH/4, word capacity (derived, not overridden)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  input  1  sole clock, rising edge
  - rst  input  1  synchronous, active-high reset
- Control:
  - start  input  1  begin a load; sampled in IDLE, DONE or ERROR only
  - len  input  ADDR_WIDTH-1  number of words to load; sampled with start
- Word stream:
  - in_valid  input  1  in_data holds a word
  - in_data  input  32  instruction word
  - in_ready  output  1  controller accepts in_data this cycle
- Memory byte write port:
  - mem_we  output  1  byte write strobe
  - mem_addr  output  ADDR_WIDTH  byte address
  - mem_wdata  output  8  byte data
- Status:
  - cpu_stall  output  1  CPU fetch/execute hold
  - done  output  1  one-cycle completion pulse
  - error  output  1  sticky length error
  - checksum  output  32  running word sum (only with IMEM_LOAD_CHECKSUM_EN)

## Operation
- States: IDLE, WAIT, WRITE, DONE, ERROR.
- IDLE:
  - in_ready=0, cpu_stall=0.
  - start with 1≤len≤MAX_WORDS → WAIT; word counter=0, base address=0, cpu_stall=1.
  - start with len=0 or len>MAX_WORDS → ERROR.
- WAIT:
  - in_ready=1.
  - in_valid&in_ready → capture in_data → WRITE; byte index=0.
- WRITE: four cycles, byte index k=0..3.
  - mem_we=1, mem_addr=base+k, mem_wdata=word[8k+7:8k].
  - After k=3: base+=4, counter+=1.
  - If counter==len → DONE, else → WAIT.
- DONE:
  - done=1 for exactly one cycle, cpu_stall=0.
  - start → WAIT (new load); otherwise → IDLE.
- ERROR:
  - error=1, cpu_stall=0, in_ready=0, mem_we=0.
  - start with valid len → WAIT; error clears on that transition.
- start outside IDLE/DONE/ERROR is ignored.
- in_valid outside WAIT is ignored; in_ready is low, no word is consumed.
- Address arithmetic is ADDR_WIDTH-bit unsigned. The len check guarantees base never wraps; mem_addr never exceeds 2**ADDR_WIDTH-1.
- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_stall=0, done=0, error=0, checksum=0
- Reset mid-load aborts immediately. Bytes already written stay in memory; no rollback.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational input-to-output paths.
- start sampled at cycle s → WAIT at s+1 (in_ready=1 from s+1).
- Word k accepted at cycle a → byte writes at a+1..a+4 → WAIT again at a+5. Peak throughput is 1 word per 5 cycles.
- Continuous in_valid with N words: last byte written at s+5N; done=1 at s+5N+1; cpu_stall falls at s+5N+1.
- in_valid gaps only stretch WAIT; there is no timeout.

## Configuration
- IMEM_LOAD_CHECKSUM_EN:
  - Defined:
    - checksum port and register exist.
    - Cleared to 0 on entry to WAIT from start.
    - Each accepted word added mod 2**32 in the acceptance cycle.
    - Value holds after DONE until the next start.
  - Undefined: port and register absent; all other behaviour identical.

## Structure
- Package imem_pkg:
  - IMEM_ADDR_WIDTH=12 and derived IMEM_MAX_WORDS
  - state enum type imem_load_state_t
- One sub-module is natural: imem_byte_sequencer.
  - Takes a 32-bit word plus a go pulse.
  - Emits four byte writes with offsets 0..3 and a last flag.
  - The controller FSM owns counters, handshake and status.

## Test plan
- Reset then idle: all outputs 0, in_ready=0; in_valid=1 with in_data=0x00000013 → no mem_we.
- start len=2, stream 0x00500093 and 0x00A00113 back-to-back:
  - byte writes addr 0..7 = 93,00,50,00,13,01,A0,00
  - done at s+11; cpu_stall high s+1..s+10
- start len=0 → ERROR, error=1, no writes. Then start len=1 → error=0, load proceeds.
- start len=1025 (ADDR_WIDTH=12) → error=1. len=1024 full load → last write addr 0xFFF, done, no wrap.
- Stalled producer: in_valid low 7 cycles inside WAIT → no writes, in_ready held 1; the word is then accepted and written normally.
- rst asserted during WRITE byte 2 of word 3 → next cycle IDLE with all outputs reset. With IMEM_LOAD_CHECKSUM_EN defined, checksum of words 1,2,3 reads 6 at done.
